shift_sequencer: RTL and testbench

//   Issue/sequencing stage in front of the combinational barrel_shifter.
//   - Accepts shift requests on a valid/ready port and decodes the opcode into num/shift_num/LbarR/ASR.
//   - Drives the shifter and captures its output into a result register.
//   - Returns the result on a valid/ready response port.
//   - Rotates (optional) take two shifter passes whose results are ORed.

---
 rtl/shift_pkg.sv | 31 +++
 rtl/barrel_shifter.sv | 25 ++
 rtl/shift_sequencer.sv | 147 ++++++++++++++
 tb/tb_shift_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Opcode encodings, FSM state type and decode helpers for shift_sequencer.
// Pure declarations; no timing or flow-control behaviour lives here.
// Rotate legality depends on the SHIFT_ROTATE_EN build macro.
package shift_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } shift_state_t;

  function automatic logic op_is_rotate(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
`ifdef SHIFT_ROTATE_EN
    return op <= OP_ROR;
`else
    return op <= OP_SRA;
`endif
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational logical/arithmetic barrel shifter (left when LbarR = 0).
// Latency: zero cycles, pure combinational.
// Backpressure: none; output follows inputs in the same cycle.
module barrel_shifter #(
  parameter int N = 32,
  parameter int B = $clog2(N)
) (
  input  logic [N-1:0] num,
  input  logic [B-1:0] shift_num,
  input  logic         LbarR,
  input  logic         ASR,
  output logic [N-1:0] out
);

  always_comb begin
    if (!LbarR) begin
      out = num << shift_num;
    end else if (ASR) begin
      out = $unsigned($signed(num) >>> shift_num);
    end else begin
      out = num >> shift_num;
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Issue stage for barrel_shifter: decodes requests, runs 1-2 shifter passes, holds result (rotates need SHIFT_ROTATE_EN).
// Latency: shift 2 edges, rotate 3 edges (2 when amt = 0), illegal opcode 1 edge from accept.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module shift_sequencer #(
  parameter int N = 32,
  parameter int B = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [N-1:0] req_data,
  input  logic [B-1:0] req_amt,
  output logic [N-1:0] sh_num,
  output logic [B-1:0] sh_amt,
  output logic         sh_LbarR,
  output logic         sh_ASR,
  input  logic [N-1:0] sh_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         rsp_err
);

  import shift_pkg::*;

  shift_state_t state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [N-1:0] data_q, data_d;
  logic [B-1:0] amt_q, amt_d;
  logic [N-1:0] acc_q, acc_d;
  logic         err_q, err_d;
  logic         accept;

`ifdef SHIFT_ROTATE_EN
  // amt_q is non-zero whenever PASS2 runs, so N - amt always fits in B bits.
  logic [B:0] inv_amt;
  assign inv_amt = (B+1)'(N) - {1'b0, amt_q};
`endif

  assign accept = req_valid && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = op_is_legal(req_op) ? PASS1 : DONE;
        end
      end
      PASS1: begin
`ifdef SHIFT_ROTATE_EN
        state_d = (op_is_rotate(op_q) && (amt_q != '0)) ? PASS2 : DONE;
`else
        state_d = DONE;
`endif
      end
`ifdef SHIFT_ROTATE_EN
      PASS2: state_d = DONE;
`endif
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    rsp_data  = acc_q;
    rsp_err   = err_q;
    sh_num    = '0;
    sh_amt    = '0;
    sh_LbarR  = 1'b0;
    sh_ASR    = 1'b0;
    case (state_q)
      PASS1: begin
        sh_num   = data_q;
        sh_amt   = amt_q;
        sh_LbarR = (op_q == OP_SRL) || (op_q == OP_SRA) || (op_q == OP_ROR);
        sh_ASR   = (op_q == OP_SRA);
      end
`ifdef SHIFT_ROTATE_EN
      // Second rotate pass goes the opposite direction to pick up the wrapped bits.
      PASS2: begin
        sh_num   = data_q;
        sh_amt   = inv_amt[B-1:0];
        sh_LbarR = (op_q == OP_ROL);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    op_d   = op_q;
    data_d = data_q;
    amt_d  = amt_q;
    acc_d  = acc_q;
    err_d  = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = req_op;
          data_d = req_data;
          amt_d  = req_amt;
          acc_d  = '0;
          err_d  = !op_is_legal(req_op);
        end
      end
      PASS1: acc_d = sh_out;
`ifdef SHIFT_ROTATE_EN
      PASS2: acc_d = acc_q | sh_out;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      data_q <= '0;
      amt_q  <= '0;
      acc_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      op_q   <= op_d;
      data_q <= data_d;
      amt_q  <= amt_d;
      acc_q  <= acc_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer driving a real barrel_shifter (N = 32).
// Expectations follow the SHIFT_ROTATE_EN build macro.
module tb_shift_sequencer;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_data;
  logic [4:0]  req_amt;
  logic [31:0] sh_num;
  logic [4:0]  sh_amt;
  logic        sh_LbarR;
  logic        sh_ASR;
  logic [31:0] sh_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  shift_sequencer #(.N(32), .B(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_data (req_data),
    .req_amt  (req_amt),
    .sh_num   (sh_num),
    .sh_amt   (sh_amt),
    .sh_LbarR (sh_LbarR),
    .sh_ASR   (sh_ASR),
    .sh_out   (sh_out),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err)
  );

  barrel_shifter #(.N(32), .B(5)) u_shifter (
    .num      (sh_num),
    .shift_num(sh_amt),
    .LbarR    (sh_LbarR),
    .ASR      (sh_ASR),
    .out      (sh_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference behaviour: expected result, error flag and edges from accept to rsp_valid.
  task automatic model(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                       output logic [31:0] ed, output logic ee, output int el);
    int sa;
    sa = int'(a);
    ed = 32'h0;
    ee = 1'b1;
    el = 1;
    case (op)
      3'd0: begin ed = d << sa; ee = 1'b0; el = 2; end
      3'd1: begin ed = d >> sa; ee = 1'b0; el = 2; end
      3'd2: begin ed = $unsigned($signed(d) >>> sa); ee = 1'b0; el = 2; end
`ifdef SHIFT_ROTATE_EN
      3'd3: begin
        ed = (sa == 0) ? d : ((d << sa) | (d >> (32 - sa)));
        ee = 1'b0;
        el = (sa == 0) ? 2 : 3;
      end
      3'd4: begin
        ed = (sa == 0) ? d : ((d >> sa) | (d << (32 - sa)));
        ee = 1'b0;
        el = (sa == 0) ? 2 : 3;
      end
`endif
      default: ;
    endcase
  endtask

  // Called at a falling edge; returns one falling edge after the accepting edge, req_valid left high.
  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                      input logic [31:0] ed, input logic ee, input int el,
                      input bit push, output int n);
    exp_t e;
    if (push) begin
      e.d = ed;
      e.e = ee;
      e.lat = el;
      exp_q.push_back(e);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    req_amt   = a;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_within_budget", 64'(n < 50), 64'd1);
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_directed(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                              input logic [31:0] ed, input logic ee, input int el);
    int n;
    send(op, d, a, ed, ee, el, 1'b1, n);
    req_valid = 1'b0;
    drain();
  endtask

  // Monitor: tracks accepts, measures latency and scores every response cycle.
  initial begin : monitor
    int acc_cyc;
    int lat;
    bit seen;
    bit outstanding;
    acc_cyc = 0;
    lat = 0;
    seen = 1'b0;
    outstanding = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        outstanding = 1'b0;
        seen = 1'b0;
      end else begin
        if (req_valid && req_ready) begin
          check("accept_only_idle", 64'(outstanding), 64'd0);
          outstanding = 1'b1;
          acc_cyc = cyc;
        end
        if (exp_q.size() == 0) begin
          check("no_unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else if (rsp_valid) begin
          if (!seen) begin
            seen = 1'b1;
            lat = cyc - acc_cyc;
          end
          check("rsp_data", 64'(rsp_data), 64'(exp_q[0].d));
          check("rsp_err", 64'(rsp_err), 64'(exp_q[0].e));
          check("req_ready_busy", 64'(req_ready), 64'd0);
          if (rsp_ready) begin
            check("latency", 64'(lat), 64'(exp_q[0].lat));
            void'(exp_q.pop_front());
            seen = 1'b0;
            outstanding = 1'b0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  a;
    logic [31:0] ed;
    logic        ee;
    int          el;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_data  = 32'h0;
    req_amt   = 5'd0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_sh_drive", 64'({sh_num, sh_amt, sh_LbarR, sh_ASR}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset with an SRL sitting in PASS1: no response may ever appear.
    send(3'd1, 32'h8000_0010, 5'd4, 32'h0, 1'b0, 0, 1'b0, n);
    check("pass1_sh_LbarR", 64'(sh_LbarR), 64'd1);
    check("pass1_sh_num", 64'(sh_num), 64'h8000_0010);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_sh_drive", 64'({sh_num, sh_amt, sh_LbarR, sh_ASR}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_stale_rsp", 64'(rsp_valid), 64'd0);

    run_directed(3'd0, 32'h0000_00F1, 5'd4, 32'h0000_0F10, 1'b0, 2);
    run_directed(3'd2, 32'h8000_0010, 5'd4, 32'hF800_0001, 1'b0, 2);
    run_directed(3'd1, 32'h8000_0010, 5'd4, 32'h0800_0001, 1'b0, 2);
    run_directed(3'd2, 32'h7000_0000, 5'd31, 32'h0000_0000, 1'b0, 2);
`ifdef SHIFT_ROTATE_EN
    run_directed(3'd3, 32'h8000_0001, 5'd1, 32'h0000_0003, 1'b0, 3);
    run_directed(3'd4, 32'h0000_0003, 5'd1, 32'h8000_0001, 1'b0, 3);
    run_directed(3'd3, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0, 2);
    run_directed(3'd4, 32'h1234_5678, 5'd8, 32'h7812_3456, 1'b0, 3);
`else
    run_directed(3'd3, 32'h0000_0001, 5'd3, 32'h0000_0000, 1'b1, 1);
    run_directed(3'd4, 32'h0000_0003, 5'd1, 32'h0000_0000, 1'b1, 1);
`endif
    run_directed(3'd7, 32'hDEAD_BEEF, 5'd2, 32'h0000_0000, 1'b1, 1);
    run_directed(3'd5, 32'h0000_FFFF, 5'd1, 32'h0000_0000, 1'b1, 1);

    // Hold the response for 5 cycles, then release it with the next request already waiting.
    rsp_ready = 1'b0;
    send(3'd0, 32'h0000_00A5, 5'd8, 32'h0000_A500, 1'b0, 2, 1'b1, n);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("bp_rsp_valid_held", 64'(rsp_valid), 64'd1);
    check("bp_req_ready", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    send(3'd1, 32'h0000_FF00, 5'd8, 32'h0000_00FF, 1'b0, 2, 1'b1, n);
    check("bp_next_accept_wait", 64'(n), 64'd1);
    req_valid = 1'b0;
    drain();

    // Back-to-back traffic with req_valid never dropping.
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      d  = $urandom;
      a  = 5'($urandom_range(0, 31));
      model(op, d, a, ed, ee, el);
      send(op, d, a, ed, ee, el, 1'b1, n);
    end
    req_valid = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
